// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default register data width and index width
//   NUM_REGS                : architectural register count (width of busy)
//   wb_entry_t              : {register index, data} pair held in the crypto FIFO
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] idx;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_entry at the tail (ignored while full)
//   push_entry  : entry to enqueue
//   pop         : drop the head entry (ignored while empty)
//   head        : current head entry, valid whenever !empty
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read asynchronously: the arbiter's output register is the only
  // pipeline stage between a queued entry and the register file.
  assign head = mem[rd_ptr_reg];

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage merging ALU and crypto results into one
// registered register-file write port, with a crypto busy scoreboard.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   alu_valid/alu_reg/alu_data         : single-cycle ALU result
//   alu_ready                          : ALU result accepted (= !fifo full)
//   crypto_valid/crypto_reg/crypto_data: crypto result, queued in a FIFO
//   crypto_ready                       : crypto result accepted (= !fifo full)
//   issue_valid/issue_reg              : crypto op issued, marks reg busy
//   busy                               : one bit per register, outstanding crypto write
//   write_enable/write_reg/write_data  : registered RF write port
// Optional: define WB_FORWARD_EN to add fwd_valid/fwd_reg/fwd_data, copies of
// the write port used by decode to bypass the register file.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_reg,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                crypto_valid,
  input  logic [ADDR_W-1:0]   crypto_reg,
  input  logic [DATA_W-1:0]   crypto_data,
  output logic                crypto_ready,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic                write_enable,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data
`ifdef WB_FORWARD_EN
  ,
  output logic                fwd_valid,
  output logic [ADDR_W-1:0]   fwd_reg,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t              push_entry;
  entry_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                alu_write;

  logic                write_enable_reg, write_enable_next;
  logic [ADDR_W-1:0]   write_reg_reg,    write_reg_next;
  logic [DATA_W-1:0]   write_data_reg,   write_data_next;
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  assign alu_ready    = !fifo_full;
  assign crypto_ready = !fifo_full;

  // Register 0 results are accepted but never written or queued, so they
  // leave the port free for a FIFO pop in the same cycle.
  assign alu_write  = alu_valid && alu_ready && (alu_reg != '0);
  assign fifo_push  = crypto_valid && crypto_ready && (crypto_reg != '0);
  assign push_entry = '{idx: crypto_reg, data: crypto_data};

  // A full FIFO always drains (the ALU is refused then); otherwise the FIFO
  // only gets the port when no ALU write claims it.
  assign fifo_pop = fifo_full || (!alu_write && !fifo_empty);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    write_enable_next = 1'b0;
    write_reg_next    = write_reg_reg;
    write_data_next   = write_data_reg;
    if (fifo_pop) begin
      write_enable_next = 1'b1;
      write_reg_next    = head.idx;
      write_data_next   = head.data;
    end else if (alu_write) begin
      write_enable_next = 1'b1;
      write_reg_next    = alu_reg;
      write_data_next   = alu_data;
    end
  end

  // Per-register set/clear decode; register 0 is never tracked.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign busy_set[gi] = 1'b0;
        assign busy_clr[gi] = 1'b0;
      end else begin : g_reg
        assign busy_set[gi] = issue_valid && (issue_reg == ADDR_W'(gi));
        assign busy_clr[gi] = fifo_pop && (head.idx == ADDR_W'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable_reg <= 1'b0;
      write_reg_reg    <= '0;
      write_data_reg   <= '0;
      busy_reg         <= '0;
    end else begin
      write_enable_reg <= write_enable_next;
      write_reg_reg    <= write_reg_next;
      write_data_reg   <= write_data_next;
      // Set is applied after clear so a same-cycle issue keeps the bit high.
      busy_reg         <= (busy_reg & ~busy_clr) | busy_set;
    end
  end

  assign write_enable = write_enable_reg;
  assign write_reg    = write_reg_reg;
  assign write_data   = write_data_reg;
  assign busy         = busy_reg;

`ifdef WB_FORWARD_EN
  assign fwd_valid = write_enable_reg;
  assign fwd_reg   = write_reg_reg;
  assign fwd_data  = write_data_reg;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed plus random stimulus against a queue-based
// reference model of the writeback arbiter.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic                clk;
  logic                rst_n;
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_reg;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_ready;
  logic                crypto_valid;
  logic [ADDR_W-1:0]   crypto_reg;
  logic [DATA_W-1:0]   crypto_data;
  logic                crypto_ready;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_reg;
  logic [NUM_REGS-1:0] busy;
  logic                write_enable;
  logic [ADDR_W-1:0]   write_reg;
  logic [DATA_W-1:0]   write_data;
`ifdef WB_FORWARD_EN
  logic                fwd_valid;
  logic [ADDR_W-1:0]   fwd_reg;
  logic [DATA_W-1:0]   fwd_data;
`endif

  wb_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .crypto_valid (crypto_valid),
    .crypto_reg   (crypto_reg),
    .crypto_data  (crypto_data),
    .crypto_ready (crypto_ready),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .busy         (busy),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending crypto results as a queue, scoreboard as a
  // plain bit vector, and the expected write-port contents.
  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t                q[$];
  logic [NUM_REGS-1:0] m_busy;
  logic                m_we;
  logic [ADDR_W-1:0]   m_wr;
  logic [DATA_W-1:0]   m_wd;
  bit                  crypto_taken;
  int                  errors = 0;
  int                  checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid    = 1'b0;
    alu_reg      = '0;
    alu_data     = '0;
    crypto_valid = 1'b0;
    crypto_reg   = '0;
    crypto_data  = '0;
    issue_valid  = 1'b0;
    issue_reg    = '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
  endtask

  // One clock cycle: inputs are already driven (called just after a falling
  // edge). Checks ready/busy before the edge, advances the model, then checks
  // the registered write port and busy after the edge.
  task automatic step(input string tag);
    bit                  full;
    bit                  alu_wr;
    bit                  push;
    ent_t                h;
    ent_t                e;
    logic [NUM_REGS-1:0] nb;
    #1;
    full = (q.size() == DEPTH);
    chk({tag, ":alu_ready"}, alu_ready, !full);
    chk({tag, ":crypto_ready"}, crypto_ready, !full);
    chk({tag, ":busy_pre"}, busy, m_busy);

    alu_wr       = alu_valid && !full && (alu_reg != 0);
    push         = crypto_valid && !full && (crypto_reg != 0);
    crypto_taken = crypto_valid && !full;
    nb           = m_busy;
    if (full || (!alu_wr && q.size() > 0)) begin
      h = q.pop_front();
      nb[h.r] = 1'b0;
      m_we = 1'b1;
      m_wr = h.r;
      m_wd = h.d;
    end else if (alu_wr) begin
      m_we = 1'b1;
      m_wr = alu_reg;
      m_wd = alu_data;
    end else begin
      m_we = 1'b0;
    end
    if (push) begin
      e.r = crypto_reg;
      e.d = crypto_data;
      q.push_back(e);
    end
    if (issue_valid && issue_reg != 0) nb[issue_reg] = 1'b1;
    m_busy = nb;

    @(posedge clk);
    #1;
    chk({tag, ":write_enable"}, write_enable, m_we);
    if (m_we) begin
      chk({tag, ":write_reg"}, write_reg, m_wr);
      chk({tag, ":write_data"}, write_data, m_wd);
    end
    chk({tag, ":busy_post"}, busy, m_busy);
`ifdef WB_FORWARD_EN
    chk({tag, ":fwd_valid"}, fwd_valid, m_we);
    if (m_we) chk({tag, ":fwd_data"}, fwd_data, m_wd);
`endif
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int guard;

    // ---- reset ----
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset:write_enable", write_enable, 1'b0);
    chk("reset:write_reg", write_reg, 0);
    chk("reset:write_data", write_data, 0);
    chk("reset:busy", busy, 0);
    chk("reset:alu_ready", alu_ready, 1'b1);
    chk("reset:crypto_ready", crypto_ready, 1'b1);
    @(negedge clk);
    step("idle");

    // ---- single ALU write ----
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    step("alu5");
    idle_inputs();
    chk("alu5:direct_reg", write_reg, 5'd5);
    chk("alu5:direct_data", write_data, 32'hDEADBEEF);
    step("alu5_after");

    // ---- issue then crypto result ----
    issue_valid = 1'b1; issue_reg = 5'd7;
    step("issue7");
    idle_inputs();
    chk("issue7:busy7_set", busy[7], 1'b1);
    crypto_valid = 1'b1; crypto_reg = 5'd7; crypto_data = 32'h11223344;
    step("crypto7_push");
    idle_inputs();
    chk("crypto7:no_write_yet", write_enable, 1'b0);
    step("crypto7_pop");
    chk("crypto7:direct_data", write_data, 32'h11223344);
    chk("crypto7:busy7_clear", busy[7], 1'b0);
    step("crypto7_after");

    // ---- contention: ALU every cycle, six crypto results ----
    idx = 0;
    guard = 0;
    while (idx < 6 && guard < 60) begin
      alu_valid    = 1'b1;
      alu_reg      = 5'(20 + (guard % 8));
      alu_data     = $urandom;
      crypto_valid = 1'b1;
      crypto_reg   = 5'(idx + 1);
      crypto_data  = 32'hC0DE0000 + 32'(idx + 1);
      step("contend");
      if (crypto_taken) idx++;
      guard++;
    end
    chk("contend:all_accepted", idx, 6);
    crypto_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      alu_data = $urandom;
      step("contend_alu_only");
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) step("contend_drain");

    // ---- register 0 in the same cycle as a non-empty FIFO ----
    crypto_valid = 1'b1; crypto_reg = 5'd3; crypto_data = 32'hA5A5_0003;
    step("r0_push3");
    idle_inputs();
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF_FFFF;
    step("r0_alu0");
    idle_inputs();
    chk("r0:head_written_reg", write_reg, 5'd3);
    chk("r0:head_written_data", write_data, 32'hA5A5_0003);
    step("r0_after");

    // ---- set/clear collision on register 9 ----
    issue_valid = 1'b1; issue_reg = 5'd9;
    step("col_issue9");
    idle_inputs();
    crypto_valid = 1'b1; crypto_reg = 5'd9; crypto_data = 32'h0909_0909;
    step("col_push9");
    idle_inputs();
    issue_valid = 1'b1; issue_reg = 5'd9;
    step("col_pop9_issue9");
    idle_inputs();
    chk("col:busy9_kept", busy[9], 1'b1);

    // ---- queue three entries behind a busy ALU, then reset ----
    for (int k = 0; k < 3; k++) begin
      alu_valid    = 1'b1; alu_reg = 5'd21; alu_data = $urandom;
      crypto_valid = 1'b1; crypto_reg = 5'(11 + k); crypto_data = $urandom;
      issue_valid  = 1'b1; issue_reg = 5'(11 + k);
      step("rst_fill");
    end
    idle_inputs();
    chk("rst_fill:queued", q.size(), 3);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst:busy", busy, 0);
    chk("midrst:write_enable", write_enable, 1'b0);
    chk("midrst:alu_ready", alu_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step("post_rst_idle");

    // ---- random traffic ----
    for (int k = 0; k < 400; k++) begin
      alu_valid    = 1'($urandom_range(0, 1));
      alu_reg      = 5'($urandom_range(0, 7));
      alu_data     = $urandom;
      crypto_valid = ($urandom_range(0, 99) < 60);
      crypto_reg   = 5'($urandom_range(0, 31));
      crypto_data  = $urandom;
      issue_valid  = ($urandom_range(0, 99) < 30);
      issue_reg    = 5'($urandom_range(0, 31));
      step("rand");
    end
    idle_inputs();
    for (int k = 0; k < 6; k++) step("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
